// File: rtl/uart_pkg.sv
// Shared types and constants for the UART bus arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    localparam logic [2:0] UART_DATA_ADDR = 3'd0;

    // The requester that did not win a grant gets the next round-robin turn.
    function automatic req_e other_req(input logic granted_b);
        return granted_b ? REQ_A : REQ_B;
    endfunction

endpackage

// File: rtl/uart_rr_grant.sv
// Two-requester round-robin grant with lock-owner override.
import uart_pkg::*;

module uart_rr_grant (
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    input  logic       own_valid,
    input  logic       own,
    input  logic       enable,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_own_valid,
    output logic       next_own
);

    logic lock_held_s;

    // An owner whose lock input has dropped no longer restricts this cycle's decision.
    always_comb begin
        lock_held_s = own_valid & lock[own];
        grant       = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else if (lock_held_s) begin
            grant = own ? {valid[1], 1'b0} : {1'b0, valid[0]};
        end else if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

    // Ownership follows the granted requester's lock; without a grant it persists while held.
    always_comb begin
        next_own_valid = 1'b0;
        next_own       = own;
        if (grant != 2'b00) begin
            next_own_valid = |(grant & lock);
            next_own       = grant[1];
        end else begin
            next_own_valid = lock_held_s;
            next_own       = own;
        end
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Sequences UART register accesses: round-robin/locked TX from two requesters
// and RX draining into a one-entry buffer, with IRQ-based flow control.
import uart_pkg::*;

module uart_bus_arbiter #(
    parameter logic [2:0] DATA_ADDR = UART_DATA_ADDR,
    parameter int         HOLDOFF   = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_a_valid,
    input  logic [7:0] i_a_data,
    input  logic       i_a_lock,
    output logic       o_a_ready,
    input  logic       i_b_valid,
    input  logic [7:0] i_b_data,
    input  logic       i_b_lock,
    output logic       o_b_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    input  logic       i_rx_ready,
    output logic [2:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_rw,
    output logic       o_en,
    output logic       o_phi2,
    input  logic [7:0] i_data,
    input  logic       i_tx_irq,
    input  logic       i_rx_irq
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    state_t     state_r;
    logic [3:0] hold_cnt_r;
    req_e       ptr_r;
    logic       own_valid_r;
    req_e       own_r;
    logic       is_read_r;
    logic       rx_valid_r;
    logic [7:0] rx_data_r;
    logic [7:0] data_r;
    logic       rw_r;
    logic       en_r;
    logic       phi2_r;

    logic       rx_take_s;
    logic       tx_en_s;
    logic [1:0] grant_s;
    logic       next_own_valid_s;
    logic       next_own_s;

    // Decisions happen only in IDLE; a pending RX read pre-empts any TX grant.
    always_comb begin
        rx_take_s = 1'b0;
        tx_en_s   = 1'b0;
        if ((state_r == S_IDLE) && !i_reset) begin
            rx_take_s = i_rx_irq & ~rx_valid_r;
            tx_en_s   = i_tx_irq & ~rx_take_s;
        end else begin
            rx_take_s = 1'b0;
            tx_en_s   = 1'b0;
        end
    end

    uart_rr_grant u_grant (
        .valid          ({i_b_valid, i_a_valid}),
        .lock           ({i_b_lock, i_a_lock}),
        .own_valid      (own_valid_r),
        .own            (own_r == REQ_B),
        .enable         (tx_en_s),
        .ptr            (ptr_r == REQ_B),
        .grant          (grant_s),
        .next_own_valid (next_own_valid_s),
        .next_own       (next_own_s)
    );

    assign o_a_ready  = grant_s[0];
    assign o_b_ready  = grant_s[1];
    assign o_addr     = DATA_ADDR;
    assign o_data     = data_r;
    assign o_rw       = rw_r;
    assign o_en       = en_r;
    assign o_phi2     = phi2_r;
    assign o_rx_valid = rx_valid_r;
    assign o_rx_data  = rx_data_r;

    // Access sequencer, bus drive registers and RX buffer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= S_IDLE;
            hold_cnt_r  <= 4'd0;
            ptr_r       <= REQ_A;
            own_valid_r <= 1'b0;
            own_r       <= REQ_A;
            is_read_r   <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= 8'd0;
            data_r      <= 8'd0;
            rw_r        <= 1'b1;
            en_r        <= 1'b0;
            phi2_r      <= 1'b0;
        end else begin
            if (rx_valid_r && i_rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    own_valid_r <= next_own_valid_s;
                    own_r       <= req_e'(next_own_s);
                    if (rx_take_s) begin
                        state_r   <= S_SETUP;
                        is_read_r <= 1'b1;
                        rw_r      <= 1'b1;
                        en_r      <= 1'b1;
                    end else if (grant_s != 2'b00) begin
                        state_r   <= S_SETUP;
                        is_read_r <= 1'b0;
                        rw_r      <= 1'b0;
                        en_r      <= 1'b1;
                        data_r    <= grant_s[1] ? i_b_data : i_a_data;
                        ptr_r     <= other_req(grant_s[1]);
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    phi2_r  <= 1'b1;
                    state_r <= S_STROBE;
                end
                S_STROBE: begin
                    en_r       <= 1'b0;
                    phi2_r     <= 1'b0;
                    hold_cnt_r <= 4'd0;
                    state_r    <= S_HOLD;
                    if (is_read_r) begin
                        rx_data_r  <= i_data;
                        rx_valid_r <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r <= 4'd0;
                        state_r    <= S_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    en_r    <= 1'b0;
                    phi2_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed self-checking bench for uart_bus_arbiter.
module tb_uart_bus_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_a_valid, i_a_lock, i_b_valid, i_b_lock;
    logic [7:0] i_a_data, i_b_data;
    logic       o_a_ready, o_b_ready;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;
    logic       i_rx_ready;
    logic [2:0] o_addr;
    logic [7:0] o_data;
    logic       o_rw, o_en, o_phi2;
    logic [7:0] i_data;
    logic       i_tx_irq, i_rx_irq;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int rd_base;
    logic [7:0] wr_q[$];
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    always #5 i_clk = ~i_clk;

    uart_bus_arbiter dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_a_valid  (i_a_valid),
        .i_a_data   (i_a_data),
        .i_a_lock   (i_a_lock),
        .o_a_ready  (o_a_ready),
        .i_b_valid  (i_b_valid),
        .i_b_data   (i_b_data),
        .i_b_lock   (i_b_lock),
        .o_b_ready  (o_b_ready),
        .o_rx_valid (o_rx_valid),
        .o_rx_data  (o_rx_data),
        .i_rx_ready (i_rx_ready),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_rw       (o_rw),
        .o_en       (o_en),
        .o_phi2     (o_phi2),
        .i_data     (i_data),
        .i_tx_irq   (i_tx_irq),
        .i_rx_irq   (i_rx_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every completed UART strobe as a write byte or a read.
    always @(negedge i_clk) begin
        if (!i_reset && o_en && o_phi2) begin
            if (!o_rw) wr_q.push_back(o_data);
            else rd_cnt++;
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_a_valid = 1'b0; i_a_lock = 1'b0; i_a_data = 8'h00;
        i_b_valid = 1'b0; i_b_lock = 1'b0; i_b_data = 8'h00;
        i_rx_ready = 1'b0; i_data = 8'h00; i_tx_irq = 1'b0; i_rx_irq = 1'b0;
        repeat (2) cyc();
        i_reset = 1'b0;
        wr_q.delete();
    endtask

    // Drive both requesters from their queues, popping on each observed handshake.
    task automatic pump(input int n);
        logic ha, hb;
        for (int i = 0; i < n; i++) begin
            i_a_valid = (a_q.size() > 0);
            i_a_data  = (a_q.size() > 0) ? a_q[0] : 8'h00;
            i_b_valid = (b_q.size() > 0);
            i_b_data  = (b_q.size() > 0) ? b_q[0] : 8'h00;
            @(negedge i_clk);
            ha = o_a_ready;
            hb = o_b_ready;
            cyc();
            if (ha && a_q.size() > 0) void'(a_q.pop_front());
            if (hb && b_q.size() > 0) void'(b_q.pop_front());
        end
        i_a_valid = (a_q.size() > 0);
        i_b_valid = (b_q.size() > 0);
    endtask

    initial begin
        // Reset values, with a request pending to show readies are held low.
        i_reset = 1'b1;
        i_a_valid = 1'b1; i_a_lock = 1'b0; i_a_data = 8'h41;
        i_b_valid = 1'b0; i_b_lock = 1'b0; i_b_data = 8'h00;
        i_rx_ready = 1'b0; i_data = 8'h00; i_tx_irq = 1'b1; i_rx_irq = 1'b0;
        repeat (3) cyc();
        @(negedge i_clk);
        check("rst_en", 32'(o_en), 32'd0);
        check("rst_phi2", 32'(o_phi2), 32'd0);
        check("rst_rw", 32'(o_rw), 32'd1);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_ready", 32'({o_a_ready, o_b_ready}), 32'd0);
        check("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        check("rst_rx_data", 32'(o_rx_data), 32'd0);

        // Single TX of 0x41 and minimum access spacing.
        cyc();
        i_reset = 1'b0;
        @(negedge i_clk);
        check("tx1_a_ready", 32'(o_a_ready), 32'd1);
        check("tx1_b_ready", 32'(o_b_ready), 32'd0);
        cyc();
        i_a_valid = 1'b0;
        @(negedge i_clk);
        check("tx1_setup_bus", 32'({o_en, o_rw, o_phi2, o_addr, o_data}), 32'({1'b1, 1'b0, 1'b0, 3'd0, 8'h41}));
        cyc();
        @(negedge i_clk);
        check("tx1_strobe", 32'({o_en, o_phi2}), 32'd3);
        cyc();
        i_a_valid = 1'b1; i_a_data = 8'h42;
        @(negedge i_clk);
        check("tx1_hold1_ready", 32'(o_a_ready), 32'd0);
        cyc();
        @(negedge i_clk);
        check("tx1_hold2_ready", 32'(o_a_ready), 32'd0);
        cyc();
        @(negedge i_clk);
        check("tx1_regrant_t5", 32'(o_a_ready), 32'd1);
        cyc();
        i_a_valid = 1'b0;
        repeat (6) cyc();
        check("tx1_write_cnt", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("tx1_wr0", 32'(wr_q[0]), 32'h41);
            check("tx1_wr1", 32'(wr_q[1]), 32'h42);
        end

        // Round-robin between two always-valid requesters.
        do_reset();
        i_tx_irq = 1'b1;
        a_q = '{8'h10, 8'h11};
        b_q = '{8'h20, 8'h21};
        pump(30);
        check("rr_write_cnt", 32'(wr_q.size()), 32'd4);
        if (wr_q.size() == 4) begin
            check("rr_wr0", 32'(wr_q[0]), 32'h10);
            check("rr_wr1", 32'(wr_q[1]), 32'h20);
            check("rr_wr2", 32'(wr_q[2]), 32'h11);
            check("rr_wr3", 32'(wr_q[3]), 32'h21);
        end

        // Locked burst from A blocks B until the lock is released.
        do_reset();
        i_tx_irq = 1'b1;
        i_a_lock = 1'b1;
        a_q = '{8'h30, 8'h31, 8'h32};
        b_q = '{8'h40};
        pump(25);
        check("lock_write_cnt", 32'(wr_q.size()), 32'd3);
        if (wr_q.size() == 3) begin
            check("lock_wr0", 32'(wr_q[0]), 32'h30);
            check("lock_wr1", 32'(wr_q[1]), 32'h31);
            check("lock_wr2", 32'(wr_q[2]), 32'h32);
        end
        @(negedge i_clk);
        check("lock_b_blocked", 32'(o_b_ready), 32'd0);
        cyc();
        i_a_lock = 1'b0;
        @(negedge i_clk);
        check("lock_release_b", 32'(o_b_ready), 32'd1);
        cyc();
        i_b_valid = 1'b0;
        repeat (8) cyc();
        check("lock_b_cnt", 32'(wr_q.size()), 32'd4);
        if (wr_q.size() == 4) check("lock_b_byte", 32'(wr_q[3]), 32'h40);

        // RX read pre-empts TX, then buffer-full backpressure.
        do_reset();
        rd_base = rd_cnt;
        i_rx_irq = 1'b1; i_data = 8'h5A; i_tx_irq = 1'b1;
        i_a_valid = 1'b1; i_a_data = 8'h77;
        @(negedge i_clk);
        check("rx_a_not_ready", 32'(o_a_ready), 32'd0);
        cyc();
        @(negedge i_clk);
        check("rx_setup", 32'({o_en, o_rw, o_phi2}), 32'b110);
        cyc();
        @(negedge i_clk);
        check("rx_strobe", 32'({o_en, o_rw, o_phi2}), 32'b111);
        cyc();
        i_data = 8'h00;
        @(negedge i_clk);
        check("rx_valid_t3", 32'(o_rx_valid), 32'd1);
        check("rx_data_t3", 32'(o_rx_data), 32'h5A);
        repeat (2) cyc();
        @(negedge i_clk);
        check("rx_full_tx_ready", 32'(o_a_ready), 32'd1);
        cyc();
        i_a_valid = 1'b0;
        @(negedge i_clk);
        check("rx_full_tx_bus", 32'({o_en, o_rw, o_data}), 32'({1'b1, 1'b0, 8'h77}));
        repeat (10) cyc();
        check("rx_no_second_read", 32'(rd_cnt - rd_base), 32'd1);
        check("rx_still_full", 32'(o_rx_valid), 32'd1);
        i_data = 8'hC3; i_rx_ready = 1'b1;
        @(negedge i_clk);
        cyc();
        i_rx_ready = 1'b0;
        @(negedge i_clk);
        check("rx_drained", 32'(o_rx_valid), 32'd0);
        repeat (3) cyc();
        @(negedge i_clk);
        check("rx2_valid", 32'(o_rx_valid), 32'd1);
        check("rx2_data", 32'(o_rx_data), 32'hC3);
        check("rx2_read_cnt", 32'(rd_cnt - rd_base), 32'd2);

        // Reset during STROBE of a TX aborts it without retry.
        do_reset();
        i_tx_irq = 1'b1; i_a_valid = 1'b1; i_a_data = 8'h99;
        @(negedge i_clk);
        check("mid_a_ready", 32'(o_a_ready), 32'd1);
        cyc();
        i_a_valid = 1'b0;
        cyc();
        @(negedge i_clk);
        check("mid_strobe", 32'(o_phi2), 32'd1);
        #1;
        i_reset = 1'b1; i_b_valid = 1'b1;
        cyc();
        @(negedge i_clk);
        check("mid_rst_bus", 32'({o_en, o_phi2, o_rw}), 32'b001);
        check("mid_rst_ready", 32'({o_a_ready, o_b_ready}), 32'd0);
        i_b_valid = 1'b0;
        cyc();
        i_reset = 1'b0;
        repeat (8) cyc();
        check("mid_no_retry", 32'(wr_q.size()), 32'd1);

        // TX stall while the UART cannot accept, grant on the same cycle the IRQ rises.
        do_reset();
        i_a_valid = 1'b1; i_a_data = 8'h55; i_tx_irq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check("stall_a_ready", 32'(o_a_ready), 32'd0);
            cyc();
        end
        i_tx_irq = 1'b1;
        @(negedge i_clk);
        check("stall_release", 32'(o_a_ready), 32'd1);
        cyc();
        i_a_valid = 1'b0;
        repeat (6) cyc();
        check("stall_write_cnt", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("stall_wr0", 32'(wr_q[0]), 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Bus master that sequences all register accesses to the `uart` peripheral and shares its transmitter between two byte-stream requesters. It sits between the system's byte producers (for example a monitor and a message streamer) and the `uart` register port. Flow control comes from the UART's `o_tx_irq`/`o_rx_irq` lines. Received bytes are drained into a one-entry output buffer.

## Interface
- `DATA_ADDR`, default `3'd0`: UART data register address, used for both TX write and RX read.
- `HOLDOFF`, default `2`: idle cycles after each access before IRQ lines are re-sampled (range 1–15).
- `i_clk` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_a_valid`, `i_a_data[8]`, `i_a_lock` in; `o_a_ready` out: requester A TX stream. Lock holds the grant across bytes.
- `i_b_valid`, `i_b_data[8]`, `i_b_lock` in; `o_b_ready` out: requester B TX stream.
- `o_rx_valid` out 1, `o_rx_data` out 8, `i_rx_ready` in 1: received-byte stream.
- `o_addr` out 3, `o_data` out 8, `o_rw` out 1, `o_en` out 1, `o_phi2` out 1: UART register port (drive `i_addr`/`i_data`/`i_rw`/`i_en`/`i_phi2`). `o_rw` is 1 for read, 0 for write.
- `i_data` in 8: UART `o_data`.
- `i_tx_irq` in 1: UART can accept a TX byte.
- `i_rx_irq` in 1: UART holds an RX byte.

## Operation
- **FSM states:**
  - IDLE → SETUP → STROBE → HOLD → IDLE.
  - Only IDLE makes decisions.
  - HOLD counts `HOLDOFF` cycles, then returns to IDLE.
- **IDLE decision priority** (highest first):
  1. **RX read.** Taken if `i_rx_irq=1` and the RX buffer is empty.
  2. **Locked owner.** If a lock owner is recorded, only that requester may be granted. It is granted when its valid is high and `i_tx_irq=1`. Otherwise nothing is granted.
  3. **Round-robin.** Among valid requesters when `i_tx_irq=1`. The pointer flips to the non-granted requester after each grant.
- **TX grant:**
  - `o_x_ready=1` in IDLE for exactly the granted requester. Combinational from state, valids, IRQs, pointer and lock.
  - The handshake latches `i_x_data` into `o_data` and sets `o_rw=0`.
  - If `i_x_lock=1` at the handshake, that requester becomes lock owner.
- **Lock release:** In IDLE, if the owner's lock input is 0, ownership clears and the same-cycle decision proceeds without a lock.
- **RX read:**
  - `o_rw=1`. `i_data` is captured on the last STROBE cycle.
  - The buffer is marked full (`o_rx_valid=1`) on entering HOLD.
  - The buffer empties on the `o_rx_valid & i_rx_ready` handshake, which may occur in any state.
- **RX buffer full:** No read is issued and the byte stays in the UART. TX may still proceed.
- **Bus drive:**
  - `o_addr=DATA_ADDR` always.
  - `o_en=1` in SETUP and STROBE only.
  - `o_phi2=1` in STROBE only.
  - `o_data` and `o_rw` are stable from SETUP through STROBE.
- **Reset** (any state, including mid-access) forces:
  - IDLE state.
  - `o_en=0`, `o_phi2=0`, `o_rw=1`, `o_data=0`, `o_addr=DATA_ADDR`.
  - `o_a_ready=o_b_ready=0`.
  - `o_rx_valid=0`, `o_rx_data=0`.
  - Pointer set to A, lock owner cleared, holdoff counter 0.

## Timing
- **Access length:** SETUP 1 cycle, STROBE 1 cycle, HOLD `HOLDOFF` cycles. Minimum spacing between accesses is 3+`HOLDOFF` cycles, which is 5 by default.
- **TX latency:** handshake in cycle T → SETUP T+1 → STROBE T+2.
- **RX latency:** decision in IDLE at cycle T → SETUP T+1, STROBE T+2 (`i_data` sampled at the end of T+2) → `o_rx_valid=1` at T+3.
- **Simultaneous events:**
  - RX-eligible plus a TX valid: RX wins and the TX requester's ready stays 0.
  - A valid and B valid with no lock: the pointer decides.
  - `i_rx_ready` during the HOLD cycle in which the buffer fills: no effect, since the buffer was empty.
- **Mid-transfer changes:** IRQ changes during SETUP/STROBE/HOLD are ignored. Requester valid may drop at any time without a handshake.

## Structure
- **Package `uart_pkg`:**
  - `state_t` enum (`S_IDLE`, `S_SETUP`, `S_STROBE`, `S_HOLD`).
  - `UART_DATA_ADDR` constant (3'd0).
  - `req_e` enum (`REQ_A`, `REQ_B`).
- **Sub-module `uart_rr_grant`** (natural to split out): two-requester round-robin with lock-owner override. Its inputs are valids, locks, enable and pointer; its outputs are one-hot grant and next owner. Everything else stays in a single module.

## Test plan
- **Single TX:** after reset, A sends 0x41 with `i_tx_irq=1`.
  - `o_a_ready` is high in cycle 1.
  - SETUP shows `o_en=1`, `o_rw=0`, `o_data=0x41`, `o_addr=0`.
  - STROBE shows `o_phi2=1`.
  - The next grant is no earlier than 5 cycles later.
- **Round-robin:** A and B continuously valid (A: 0x10, 0x11; B: 0x20, 0x21), no locks → UART write order 0x10, 0x20, 0x11, 0x21.
- **Lock:** A asserts lock for bytes 0x30, 0x31, 0x32 while B is valid.
  - All three A bytes are written before any B byte.
  - Clearing `i_a_lock` lets B's byte be granted at the next IDLE.
- **RX priority and backpressure:**
  - `i_rx_irq=1`, `i_data=0x5A`, A valid → read issued first and `o_rx_valid=1` with 0x5A 3 cycles after the decision.
  - Hold `i_rx_ready=0` → no second read while TX continues.
- **Reset mid-access:** assert `i_reset` during STROBE of a TX → next cycle `o_en=0`, `o_phi2=0`, `o_rw=1`, and both readies are 0. The byte is not retried.
- **TX stall:** `i_tx_irq=0` with A valid → `o_a_ready` stays 0 indefinitely. Raising `i_tx_irq` yields the grant in the same cycle.
